// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding and PC source select codes.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_HALT      = 3'd1,
        ST_INT_FLUSH = 3'd2,
        ST_INT_PUSH  = 3'd3,
        ST_INT_VEC   = 3'd4
    } state_e;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_VEC = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: decode reads a register that the load in Ex
// has not yet produced. Pure combinational, shared with forwarding.
module hazard_detect (
    input  logic [1:0] d_ra,
    input  logic [1:0] d_rb,
    input  logic       d_use_ra,
    input  logic       d_use_rb,
    input  logic [1:0] ex_rd,
    input  logic       ex_RW,
    input  logic       ex_mem_rd,
    output logic       lu
);

    logic hit_a;
    logic hit_b;

    assign hit_a = d_use_ra & (d_ra == ex_rd);
    assign hit_b = d_use_rb & (d_rb == ex_rd);
    assign lu    = ex_mem_rd & ex_RW & (hit_a | hit_b);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: latch strobes, load-use stalls,
// branch flushes, halt and interrupt entry sequencing.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             d_ra,
    input  logic [1:0]             d_rb,
    input  logic                   d_use_ra,
    input  logic                   d_use_rb,
    input  logic [1:0]             ex_rd,
    input  logic                   ex_RW,
    input  logic                   ex_mem_rd,
    input  logic                   ex_branch_taken,
    input  logic                   ex_Hlt,
    input  logic                   int_req,
    input  logic                   int_en,
    output logic                   pc_ld,
    output logic [1:0]             pc_sel,
    output logic                   fd_ld,
    output logic                   fd_flush,
    output logic                   dex_ld,
    output logic                   dex_flush,
    output logic                   exm_ld,
    output logic                   inj_push_pc,
    output logic                   int_ack,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ack_q, halted_q;
    logic                   lu;
    logic                   irq;
    logic                   stall_evt;

    hazard_detect u_hd (
        .d_ra      (d_ra),
        .d_rb      (d_rb),
        .d_use_ra  (d_use_ra),
        .d_use_rb  (d_use_rb),
        .ex_rd     (ex_rd),
        .ex_RW     (ex_RW),
        .ex_mem_rd (ex_mem_rd),
        .lu        (lu)
    );

    assign irq       = int_req & int_en;
    assign stall_evt = (state_q == ST_RUN) & ~ex_branch_taken
                     & ~ex_Hlt & lu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= (state_q == ST_INT_VEC);
            halted_q <= (state_d == ST_HALT);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stall_evt && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
            ST_RUN: begin
                if (ex_branch_taken)  state_d = ST_RUN;
                else if (ex_Hlt)      state_d = ST_HALT;
                else if (lu)          state_d = ST_RUN;
                else if (irq)         state_d = ST_INT_FLUSH;
            end
            ST_HALT:      if (irq) state_d = ST_INT_FLUSH;
            ST_INT_FLUSH: state_d = ST_INT_PUSH;
            ST_INT_PUSH:  state_d = ST_INT_VEC;
            ST_INT_VEC:   state_d = ST_RUN;
            default:      state_d = ST_RUN;
        endcase
    end

    // Latches clear themselves on reset, so every strobe is held low then.
    always_comb begin
        pc_ld       = 1'b0;
        pc_sel      = PC_SEQ;
        fd_ld       = 1'b0;
        fd_flush    = 1'b0;
        dex_ld      = 1'b0;
        dex_flush   = 1'b0;
        exm_ld      = 1'b0;
        inj_push_pc = 1'b0;
        if (reset) begin
            pc_ld  = 1'b1;
            fd_ld  = 1'b1;
            dex_ld = 1'b1;
            exm_ld = 1'b1;
            unique case (state_q)
                ST_RUN: begin
                    if (ex_branch_taken) begin
                        pc_sel    = PC_BR;
                        fd_flush  = 1'b1;
                        dex_flush = 1'b1;
                    end else if (ex_Hlt || lu) begin
                        pc_ld     = 1'b0;
                        fd_ld     = 1'b0;
                        dex_flush = 1'b1;
                    end
                end
                ST_HALT: begin
                    pc_ld     = 1'b0;
                    fd_ld     = 1'b0;
                    dex_flush = 1'b1;
                end
                ST_INT_FLUSH: begin
                    pc_ld     = 1'b0;
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                end
                ST_INT_PUSH: begin
                    pc_ld       = 1'b0;
                    fd_ld       = 1'b0;
                    inj_push_pc = 1'b1;
                end
                ST_INT_VEC: begin
                    pc_sel    = PC_VEC;
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                end
                default: begin
                    pc_ld  = 1'b0;
                    fd_ld  = 1'b0;
                    dex_ld = 1'b0;
                    exm_ld = 1'b0;
                end
            endcase
        end
    end

    assign int_ack   = ack_q;
    assign halted    = halted_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed vectors push expected
// outputs; a monitor pops and compares at each falling edge.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [1:0] ra;
        logic [1:0] rb;
        logic       ua;
        logic       ub;
        logic [1:0] rd;
        logic       rw;
        logic       mrd;
        logic       br;
        logic       hlt;
        logic       ireq;
        logic       ien;
    } in_t;

    typedef struct packed {
        logic [8:0] strb;
        logic       ack;
        logic       hlt;
        logic [7:0] cnt;
    } obs_t;

    typedef struct packed {
        obs_t o;
        int   id;
    } exp_t;

    // {pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush, exm_ld, inj}
    localparam logic [8:0] S_RUN = 9'b1_00_1_0_1_0_1_0;
    localparam logic [8:0] S_STL = 9'b0_00_0_0_1_1_1_0;
    localparam logic [8:0] S_BR  = 9'b1_01_1_1_1_1_1_0;
    localparam logic [8:0] S_IFL = 9'b0_00_1_1_1_1_1_0;
    localparam logic [8:0] S_IPU = 9'b0_00_0_0_1_0_1_1;
    localparam logic [8:0] S_IVC = 9'b1_10_1_1_1_1_1_0;
    localparam logic [8:0] S_RST = 9'b0_00_0_0_0_0_0_0;

    logic       clk = 1'b0;
    logic       chk_now = 1'b0;
    in_t        cur;
    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         vid = 0;

    logic       pc_ld, fd_ld, fd_flush, dex_ld, dex_flush, exm_ld;
    logic       inj_push_pc, int_ack, halted;
    logic [1:0] pc_sel;
    logic [7:0] stall_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CNT_W(8)) dut (
        .clk             (clk),
        .reset           (cur.rst),
        .d_ra            (cur.ra),
        .d_rb            (cur.rb),
        .d_use_ra        (cur.ua),
        .d_use_rb        (cur.ub),
        .ex_rd           (cur.rd),
        .ex_RW           (cur.rw),
        .ex_mem_rd       (cur.mrd),
        .ex_branch_taken (cur.br),
        .ex_Hlt          (cur.hlt),
        .int_req         (cur.ireq),
        .int_en          (cur.ien),
        .pc_ld           (pc_ld),
        .pc_sel          (pc_sel),
        .fd_ld           (fd_ld),
        .fd_flush        (fd_flush),
        .dex_ld          (dex_ld),
        .dex_flush       (dex_flush),
        .exm_ld          (exm_ld),
        .inj_push_pc     (inj_push_pc),
        .int_ack         (int_ack),
        .halted          (halted),
        .stall_cnt       (stall_cnt)
    );

    function automatic in_t mk(
        input logic rst, input logic [1:0] ra, input logic [1:0] rb,
        input logic ua, input logic ub, input logic [1:0] rd,
        input logic rw, input logic mrd, input logic br,
        input logic hlt, input logic ireq, input logic ien);
        in_t v;
        v = '{rst, ra, rb, ua, ub, rd, rw, mrd, br, hlt, ireq, ien};
        return v;
    endfunction

    function automatic obs_t ex(input logic [8:0] s, input logic a,
                                input logic h, input logic [7:0] c);
        obs_t v;
        v = '{s, a, h, c};
        return v;
    endfunction

    task automatic vec(input in_t i, input obs_t e);
        exp_t x;
        @(posedge clk);
        #1;
        cur = i;
        vid++;
        x.o  = e;
        x.id = vid;
        q.push_back(x);
    endtask

    always @(negedge clk or posedge chk_now) begin
        exp_t x;
        obs_t act;
        if (q.size() > 0) begin
            x   = q.pop_front();
            act = {pc_ld, pc_sel, fd_ld, fd_flush, dex_ld, dex_flush,
                   exm_ld, inj_push_pc, int_ack, halted, stall_cnt};
            n_cmp++;
            if (act !== x.o) begin
                n_bad++;
                $display("FAIL vec%0d: got %b_%b_%b_%0d want %b_%b_%b_%0d",
                         x.id, act.strb, act.ack, act.hlt, act.cnt,
                         x.o.strb, x.o.ack, x.o.hlt, x.o.cnt);
            end
        end
    end

    initial begin
        in_t idle, rst0, ld_a, ld_a_nouse, ld_b, br_lu, hlt, irq, irq_off;
        in_t br_irq, lu_irq;
        idle       = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst0       = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld_a       = mk(1, 2, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0);
        ld_a_nouse = mk(1, 2, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        ld_b       = mk(1, 1, 2, 0, 1, 2, 1, 1, 0, 0, 0, 0);
        br_lu      = mk(1, 2, 0, 1, 0, 2, 1, 1, 1, 0, 0, 0);
        hlt        = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        irq        = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        irq_off    = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        br_irq     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
        lu_irq     = mk(1, 2, 0, 1, 0, 2, 1, 1, 0, 0, 1, 1);

        cur = idle;
        #2;
        cur = rst0;
        vec(rst0, ex(S_RST, 0, 0, 0));
        vec(rst0, ex(S_RST, 0, 0, 0));
        vec(idle, ex(S_RUN, 0, 0, 0));
        // load-use on ra, then recovery
        vec(ld_a, ex(S_STL, 0, 0, 0));
        vec(idle, ex(S_RUN, 0, 0, 1));
        vec(ld_a_nouse, ex(S_RUN, 0, 0, 1));
        vec(idle, ex(S_RUN, 0, 0, 1));
        // branch outranks load-use
        vec(br_lu, ex(S_BR, 0, 0, 1));
        vec(idle, ex(S_RUN, 0, 0, 1));
        vec(ld_b, ex(S_STL, 0, 0, 1));
        vec(idle, ex(S_RUN, 0, 0, 2));
        for (int k = 0; k < 10; k++) vec(irq_off, ex(S_RUN, 0, 0, 2));
        vec(idle, ex(S_RUN, 0, 0, 2));
        // halt, then wake on interrupt
        vec(hlt, ex(S_STL, 0, 0, 2));
        vec(idle, ex(S_STL, 0, 1, 2));
        vec(br_lu, ex(S_STL, 0, 1, 2));
        vec(irq_off, ex(S_STL, 0, 1, 2));
        vec(irq, ex(S_STL, 0, 1, 2));
        vec(br_irq, ex(S_IFL, 0, 0, 2));
        vec(idle, ex(S_IPU, 0, 0, 2));
        vec(idle, ex(S_IVC, 0, 0, 2));
        vec(idle, ex(S_RUN, 1, 0, 2));
        vec(idle, ex(S_RUN, 0, 0, 2));
        // interrupt taken from RUN; lu ignored during entry
        vec(irq, ex(S_RUN, 0, 0, 2));
        vec(lu_irq, ex(S_IFL, 0, 0, 2));
        vec(lu_irq, ex(S_IPU, 0, 0, 2));
        vec(idle, ex(S_IVC, 0, 0, 2));
        vec(idle, ex(S_RUN, 1, 0, 2));
        // saturate the stall counter
        for (int k = 0; k < 300; k++)
            vec(ld_a, ex(S_STL, 0, 0, (k + 2 > 255) ? 8'd255 : 8'(k + 2)));
        vec(idle, ex(S_RUN, 0, 0, 255));
        vec(ld_a, ex(S_STL, 0, 0, 255));
        vec(idle, ex(S_RUN, 0, 0, 255));
        // reset asserted in the middle of INT_PUSH
        vec(irq, ex(S_RUN, 0, 0, 255));
        vec(idle, ex(S_IFL, 0, 0, 255));
        vec(idle, ex(S_IPU, 0, 0, 255));
        @(negedge clk);
        #2;
        cur = rst0;
        begin
            exp_t x;
            vid++;
            x.o  = ex(S_RST, 0, 0, 0);
            x.id = vid;
            q.push_back(x);
        end
        #1 chk_now = 1'b1;
        #1 chk_now = 1'b0;
        vec(rst0, ex(S_RST, 0, 0, 0));
        vec(idle, ex(S_RUN, 0, 0, 0));
        vec(idle, ex(S_RUN, 0, 0, 0));
        vec(idle, ex(S_RUN, 0, 0, 0));

        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
